// File: rtl/i2c_pkg.sv
// Shared I2C responder definitions: FSM states, sensor frame layout and bus addresses.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE_BYTE,
        WRITE_ACK,
        READ_BYTE,
        READ_ACK,
        IGNORE
    } i2c_state_e;

    localparam logic [6:0] SENSOR_ADDR = 7'h35;
    localparam logic [6:0] MUX_ADDR    = 7'h70;

    // Continuous-readout frame layout
    localparam int FRAME_BYTES  = 7;
    localparam int FB_MAG_X_HI  = 0;
    localparam int FB_MAG_Y_HI  = 1;
    localparam int FB_MAG_Z_HI  = 2;
    localparam int FB_TEMP_HI   = 3;
    localparam int FB_XY_LO     = 4;
    localparam int FB_Z_LO      = 5;
    localparam int FB_TEMP_LO   = 6;

    typedef logic [FRAME_BYTES-1:0][7:0] frame_t;

    typedef struct packed {
        logic [11:0] mag_x;
        logic [11:0] mag_y;
        logic [11:0] mag_z;
        logic [11:0] temp;
    } sample_t;

    // Pack one sensor sample plus the rolling frame counter into the read frame
    function automatic frame_t build_frame(input sample_t s, input logic [1:0] cnt);
        frame_t f;
        f[FB_MAG_X_HI] = s.mag_x[11:4];
        f[FB_MAG_Y_HI] = s.mag_y[11:4];
        f[FB_MAG_Z_HI] = s.mag_z[11:4];
        f[FB_TEMP_HI]  = {s.temp[11:8], cnt, 2'b00};
        f[FB_XY_LO]    = {s.mag_x[3:0], s.mag_y[3:0]};
        f[FB_Z_LO]     = {4'b0000, s.mag_z[3:0]};
        f[FB_TEMP_LO]  = s.temp[7:0];
        return f;
    endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// I2C bus front end: pad synchronizers, SCL edge detection and START/STOP detection.
module i2c_bus_monitor (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic sda_o,
    output logic start_o,
    output logic stop_o
);
    // [0],[1] = 2-flop synchronizer, [2] = history for edge detection.
    // Reset to 1 (idle bus) so no phantom edge appears after reset.
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Synchronize the raw pad lines and keep one sample of history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    assign sda_o      = sda_q[1];
    assign scl_rise_o =  scl_q[1] & ~scl_q[2];
    assign scl_fall_o = ~scl_q[1] &  scl_q[2];
    // SDA may only move while SCL is high for bus conditions
    assign start_o    = scl_q[1] & scl_q[2] &  sda_q[2] & ~sda_q[1];
    assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/i2c_mag_sensor_responder.sv
// I2C target emulating a 3-axis magnetic/temperature sensor: serves a snapshot
// readout frame and accepts configuration register writes.
module i2c_mag_sensor_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR    = SENSOR_ADDR,
    parameter int         NUM_READ_BYTES = FRAME_BYTES,
    parameter int         NUM_CFG_REGS   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scl,
    input  logic                      sda_in,
    output logic                      sda_oe,
    input  logic [11:0]               mag_x,
    input  logic [11:0]               mag_y,
    input  logic [11:0]               mag_z,
    input  logic [11:0]               temperature,
    input  logic                      sample_valid,
    output logic [8*NUM_CFG_REGS-1:0] cfg_regs,
    output logic                      cfg_wr_strobe,
    output logic [7:0]                cfg_wr_index,
    output logic [7:0]                cfg_wr_data,
    output logic                      busy
);
    localparam int RD_W = (NUM_READ_BYTES > 1) ? $clog2(NUM_READ_BYTES) : 1;
    localparam int WR_W = (NUM_CFG_REGS > 1) ? $clog2(NUM_CFG_REGS) : 1;

    logic scl_rise, scl_fall, sda, start, stop;

    i2c_bus_monitor u_bus (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (scl),
        .sda_i      (sda_in),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .sda_o      (sda),
        .start_o    (start),
        .stop_o     (stop)
    );

    i2c_state_e                           state_q, state_d;
    logic [3:0]                           bit_cnt_q, bit_cnt_d;
    logic [6:0]                           shift_q, shift_d;
    logic                                 rw_q, rw_d;
    logic                                 ph_q, ph_d;
    logic [RD_W-1:0]                      rd_ptr_q, rd_ptr_d;
    logic [WR_W-1:0]                      wr_ptr_q, wr_ptr_d;
    logic [NUM_READ_BYTES-1:0][7:0]       tx_frame_q, tx_frame_d;
    logic                                 sda_oe_q, sda_oe_d;
    logic                                 busy_q, busy_d;
    logic [NUM_CFG_REGS-1:0][7:0]         cfg_regs_q, cfg_regs_d;
    logic                                 strobe_q, strobe_d;
    logic [7:0]                           index_q, index_d;
    logic [7:0]                           data_q, data_d;
    sample_t                              shadow_q, shadow_d;
    logic [1:0]                           frame_cnt_q, frame_cnt_d;

    logic                                 addr_hit;
    logic [RD_W-1:0]                      rd_nxt;
    logic [WR_W-1:0]                      wr_nxt;
    logic [7:0]                           wr_byte;
    frame_t                               snap_w;
    logic [NUM_READ_BYTES-1:0][7:0]       snap_ext;

    // Shift register holds address bits 7..1 when the 8th bit arrives
    assign addr_hit = (shift_q == DEVICE_ADDR);
    assign rd_nxt   = (rd_ptr_q == RD_W'(NUM_READ_BYTES-1)) ? '0 : rd_ptr_q + RD_W'(1);
    assign wr_nxt   = (wr_ptr_q == WR_W'(NUM_CFG_REGS-1)) ? '0 : wr_ptr_q + WR_W'(1);
    assign wr_byte  = {shift_q, sda};
    // Built from registered shadows, so a coincident sample_valid is not seen
    assign snap_w   = build_frame(shadow_q, frame_cnt_q);

    for (genvar i = 0; i < NUM_READ_BYTES; i++) begin : g_snap
        if (i < FRAME_BYTES) begin : g_b
            assign snap_ext[i] = snap_w[i];
        end else begin : g_z
            assign snap_ext[i] = '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; bus conditions override every state
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ADDR;
        end else if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                ADDR:       if (scl_rise && bit_cnt_q == 4'd7) state_d = addr_hit ? ADDR_ACK : IGNORE;
                ADDR_ACK:   if (scl_fall && ph_q) state_d = rw_q ? READ_BYTE : WRITE_BYTE;
                WRITE_BYTE: if (scl_rise && bit_cnt_q == 4'd7) state_d = WRITE_ACK;
                WRITE_ACK:  if (scl_fall && ph_q) state_d = WRITE_BYTE;
                READ_BYTE:  if (scl_fall && bit_cnt_q == 4'd8) state_d = READ_ACK;
                READ_ACK: begin
                    if (scl_rise && sda)       state_d = IDLE;
                    else if (scl_fall && ph_q) state_d = READ_BYTE;
                end
                default: ;
            endcase
        end
    end

    // FSM outputs and datapath: sample on SCL rise, move SDA only on SCL fall.
    // ph_q marks the second half of an ACK slot (ACK driven / master ACK seen).
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ph_d        = ph_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        tx_frame_d  = tx_frame_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        cfg_regs_d  = cfg_regs_q;
        strobe_d    = 1'b0;
        index_d     = index_q;
        data_d      = data_q;
        shadow_d    = shadow_q;
        frame_cnt_d = frame_cnt_q;

        if (sample_valid) begin
            shadow_d    = '{mag_x: mag_x, mag_y: mag_y, mag_z: mag_z, temp: temperature};
            frame_cnt_d = frame_cnt_q + 2'd1;
        end

        if (start) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop) begin
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rw_d   = sda;
                            ph_d   = 1'b0;
                            busy_d = addr_hit;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ph_q) begin
                            sda_oe_d = 1'b1;
                            ph_d     = 1'b1;
                        end else begin
                            bit_cnt_d = '0;
                            if (rw_q) begin
                                tx_frame_d = snap_ext;
                                rd_ptr_d   = '0;
                                sda_oe_d   = ~snap_ext[0][7];
                            end else begin
                                wr_ptr_d   = '0;
                                sda_oe_d   = 1'b0;
                            end
                        end
                    end
                end
                WRITE_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            cfg_regs_d[wr_ptr_q] = wr_byte;
                            strobe_d  = 1'b1;
                            index_d   = 8'(wr_ptr_q);
                            data_d    = wr_byte;
                            wr_ptr_d  = wr_nxt;
                            ph_d      = 1'b0;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!ph_q) begin
                            sda_oe_d  = 1'b1;
                            ph_d      = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                        end
                    end
                end
                READ_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            ph_d     = 1'b0;
                        end else begin
                            // after k bits have gone out, bit 7-k is next
                            sda_oe_d = ~tx_frame_q[rd_ptr_q][~bit_cnt_q[2:0]];
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        if (sda) busy_d = 1'b0;
                        else     ph_d   = 1'b1;
                    end else if (scl_fall && ph_q) begin
                        rd_ptr_d  = rd_nxt;
                        bit_cnt_d = '0;
                        sda_oe_d  = ~tx_frame_q[rd_nxt][7];
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            ph_q        <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            tx_frame_q  <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            cfg_regs_q  <= '0;
            strobe_q    <= 1'b0;
            index_q     <= '0;
            data_q      <= '0;
            shadow_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ph_q        <= ph_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            tx_frame_q  <= tx_frame_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            cfg_regs_q  <= cfg_regs_d;
            strobe_q    <= strobe_d;
            index_q     <= index_d;
            data_q      <= data_d;
            shadow_q    <= shadow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign sda_oe        = sda_oe_q;
    assign busy          = busy_q;
    assign cfg_regs      = cfg_regs_q;
    assign cfg_wr_strobe = strobe_q;
    assign cfg_wr_index  = index_q;
    assign cfg_wr_data   = data_q;

endmodule

// File: tb/tb_i2c_mag_sensor_responder.sv
// Scoreboard bench for the I2C sensor responder: a bit-banged bus master drives
// directed transactions, a monitor compares observations against expectations.
module tb_i2c_mag_sensor_responder;

    localparam int QTR = 200;   // quarter SCL period, 20 clk

    typedef struct {
        string       tag;
        logic [31:0] val;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic [11:0] mag_x = '0, mag_y = '0, mag_z = '0, temperature = '0;
    logic        sample_valid = 1'b0;
    logic [31:0] cfg_regs;
    logic        cfg_wr_strobe;
    logic [7:0]  cfg_wr_index, cfg_wr_data;
    logic        busy;

    assign sda_line = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_mag_sensor_responder dut (
        .clk           (clk),
        .reset         (reset),
        .scl           (scl),
        .sda_in        (sda_line),
        .sda_oe        (sda_oe),
        .mag_x         (mag_x),
        .mag_y         (mag_y),
        .mag_z         (mag_z),
        .temperature   (temperature),
        .sample_valid  (sample_valid),
        .cfg_regs      (cfg_regs),
        .cfg_wr_strobe (cfg_wr_strobe),
        .cfg_wr_index  (cfg_wr_index),
        .cfg_wr_data   (cfg_wr_data),
        .busy          (busy)
    );

    item_t       exp_wr_q[$];
    item_t       exp_rd_q[$], obs_rd_q[$];
    item_t       exp_ck_q[$], obs_ck_q[$];
    int          n_cmp = 0, n_err = 0, oe_cnt = 0;
    logic        done = 1'b0, final_done = 1'b0;

    // ---------------- scoreboard helpers ----------------
    function automatic void expect_ck(input string tag, input logic [31:0] exp_v, input logic [31:0] got_v);
        exp_ck_q.push_back('{tag: tag, val: exp_v});
        obs_ck_q.push_back('{tag: tag, val: got_v});
    endfunction

    function automatic void push_rd(input string tag, input int n, input logic [79:0] v);
        for (int i = 0; i < n; i++)
            exp_rd_q.push_back('{tag: $sformatf("%s_b%0d", tag, i), val: {24'h0, v[8*(n-1-i) +: 8]}});
    endfunction

    function automatic void push_wr(input string tag, input logic [7:0] idx, input logic [7:0] d);
        exp_wr_q.push_back('{tag: tag, val: {16'h0, idx, d}});
    endfunction

    // ---------------- bus master ----------------
    task automatic bus_start();
        m_sda = 1'b1; #QTR; scl = 1'b1; #QTR; m_sda = 1'b0; #QTR; scl = 1'b0; #QTR;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #QTR; scl = 1'b1; #QTR; m_sda = 1'b1; #QTR;
    endtask

    task automatic put_bit(input logic b);
        m_sda = b; #QTR; scl = 1'b1; #(2*QTR); scl = 1'b0; #QTR;
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; #QTR; scl = 1'b1; #QTR; b = sda_line; #QTR; scl = 1'b0; #QTR;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(nack);
    endtask

    task automatic read_bytes(input int n, input logic nack_last);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            get_byte(nack_last && (i == n-1), d);
            obs_rd_q.push_back('{tag: "rd", val: {24'h0, d}});
        end
    endtask

    task automatic pulse_sample(input logic [11:0] x, input logic [11:0] y,
                                input logic [11:0] z, input logic [11:0] t);
        mag_x = x; mag_y = y; mag_z = z; temperature = t;
        @(posedge clk); #1 sample_valid = 1'b1;
        @(posedge clk); #1 sample_valid = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        item_t e, o;
        forever begin
            @(negedge clk);
            if (sda_oe) oe_cnt++;
            if (cfg_wr_strobe) begin
                n_cmp++;
                if (exp_wr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_strobe: got idx=%0d data=%02h, expected no write", cfg_wr_index, cfg_wr_data);
                end else begin
                    e = exp_wr_q.pop_front();
                    if ({16'h0, cfg_wr_index, cfg_wr_data} !== e.val) begin
                        n_err++;
                        $display("FAIL %s: got idx/data %04h, expected %04h", e.tag,
                                 {cfg_wr_index, cfg_wr_data}, e.val[15:0]);
                    end
                end
            end
            while (obs_rd_q.size() > 0) begin
                o = obs_rd_q.pop_front();
                n_cmp++;
                if (exp_rd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_extra: got %02h, expected no byte", o.val[7:0]);
                end else begin
                    e = exp_rd_q.pop_front();
                    if (o.val !== e.val) begin
                        n_err++;
                        $display("FAIL %s: got %02h, expected %02h", e.tag, o.val[7:0], e.val[7:0]);
                    end
                end
            end
            while (obs_ck_q.size() > 0) begin
                o = obs_ck_q.pop_front();
                e = exp_ck_q.pop_front();
                n_cmp++;
                if (o.val !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got %0h, expected %0h", e.tag, o.val, e.val);
                end
            end
            if (done && !final_done) begin
                n_cmp++;
                if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
                    n_err++;
                    $display("FAIL leftover: got %0d writes / %0d bytes still pending, expected 0 / 0",
                             exp_wr_q.size(), exp_rd_q.size());
                end
                final_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic ack;
        int   oe0;
        int   waited;

        #3;
        expect_ck("rst_sda_oe",   32'h0, {31'h0, sda_oe});
        expect_ck("rst_busy",     32'h0, {31'h0, busy});
        expect_ck("rst_cfg_regs", 32'h0, cfg_regs);
        expect_ck("rst_cfg_wr",   32'h0, {15'h0, cfg_wr_strobe, cfg_wr_index, cfg_wr_data});
        #50 reset = 1'b0;
        #100;

        // T1: 7-byte read, NACK last
        pulse_sample(12'hABC, 12'h123, 12'h7F5, 12'h456);
        push_rd("t1", 7, 80'hAB127F44C30556);
        bus_start();
        put_byte(8'h6B, ack);
        expect_ck("t1_addr_ack", 32'h0, {31'h0, ack});
        expect_ck("t1_busy",     32'h1, {31'h0, busy});
        read_bytes(7, 1'b1);
        expect_ck("t1_busy_nack", 32'h0, {31'h0, busy});
        bus_stop();

        // T2: protocol-change write 0x11, 0x10
        push_wr("t2_wr0", 8'd0, 8'h11);
        push_wr("t2_wr1", 8'd1, 8'h10);
        bus_start();
        put_byte(8'h6A, ack); expect_ck("t2_ack_addr", 32'h0, {31'h0, ack});
        put_byte(8'h11, ack); expect_ck("t2_ack_d0",   32'h0, {31'h0, ack});
        put_byte(8'h10, ack); expect_ck("t2_ack_d1",   32'h0, {31'h0, ack});
        bus_stop();
        expect_ck("t2_cfg_regs", 32'h0000_1011, cfg_regs);

        // T3: foreign address 0x36 is ignored
        oe0 = oe_cnt;
        bus_start();
        put_byte(8'h6C, ack);
        expect_ck("t3_nack", 32'h1, {31'h0, ack});
        expect_ck("t3_busy", 32'h0, {31'h0, busy});
        bus_stop();
        #(QTR);
        expect_ck("t3_oe_cnt", 32'h0, oe_cnt - oe0);

        // T4: 10-byte read wraps; new sample mid-read must not leak in
        push_rd("t4", 10, 80'hAB127F44C30556AB127F);
        bus_start();
        put_byte(8'h6B, ack);
        expect_ck("t4_addr_ack", 32'h0, {31'h0, ack});
        read_bytes(3, 1'b0);
        pulse_sample(12'h5A0, 12'hF0F, 12'h001, 12'hFED);
        read_bytes(7, 1'b1);
        expect_ck("t4_busy_nack", 32'h0, {31'h0, busy});
        bus_stop();

        // T5: write then repeated START read; frame_cnt now 2
        push_wr("t5_wr0", 8'd0, 8'h22);
        push_rd("t5", 7, 80'h5AF000F80F01ED);
        bus_start();
        put_byte(8'h6A, ack); expect_ck("t5_ack_addr", 32'h0, {31'h0, ack});
        put_byte(8'h22, ack); expect_ck("t5_ack_d0",   32'h0, {31'h0, ack});
        bus_start();
        put_byte(8'h6B, ack); expect_ck("t5_ack_rd",   32'h0, {31'h0, ack});
        expect_ck("t5_busy", 32'h1, {31'h0, busy});
        read_bytes(7, 1'b1);
        bus_stop();
        expect_ck("t5_cfg_regs", 32'h0000_1022, cfg_regs);

        // T6: reset while driving a 0 data bit
        bus_start();
        put_byte(8'h6B, ack);
        expect_ck("t6_addr_ack", 32'h0, {31'h0, ack});
        expect_ck("t6_oe_pre",   32'h1, {31'h0, sda_oe});
        reset = 1'b1;
        #1;
        expect_ck("t6_oe_rst",   32'h0, {31'h0, sda_oe});
        expect_ck("t6_cfg_rst",  32'h0, cfg_regs);
        expect_ck("t6_busy_rst", 32'h0, {31'h0, busy});
        #30 reset = 1'b0;
        #20;
        bus_stop();
        pulse_sample(12'h123, 12'h456, 12'h789, 12'hABC);
        push_rd("t6", 7, 80'h124578A43609BC);
        bus_start();
        put_byte(8'h6B, ack);
        expect_ck("t6_ack_after", 32'h0, {31'h0, ack});
        read_bytes(7, 1'b1);
        expect_ck("t6_busy_nack", 32'h0, {31'h0, busy});
        bus_stop();

        #(QTR);
        done = 1'b1;
        waited = 0;
        while (!final_done && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        if (!final_done) begin
            n_cmp++;
            n_err++;
            $display("FAIL monitor_drain: got no final check, expected one within 200 clk");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
